// File: rtl/llm_outlier_pkg.sv
// Shared types and constants for the activation-tile outlier scanner.
// Thresholds are the inclusive magnitude limits beyond which an element counts as an outlier.
package llm_outlier_pkg;

    typedef enum logic {
        SCAN = 1'b0,
        DONE = 1'b1
    } scan_state_t;

    localparam logic signed [15:0] OUTLIER_POS_THRES = 16'sd128;
    localparam logic signed [15:0] OUTLIER_NEG_THRES = -16'sd128;

endpackage

// File: rtl/llm_outlier_flag.sv
// Combinational per-element outlier test on one signed 16-bit lane.
// Flags x >= 128 or x <= -128.
module llm_outlier_flag
    import llm_outlier_pkg::*;
(
    input  logic [15:0] i_data,
    output logic        o_flag
);

    logic signed [15:0] w_x;

    assign w_x    = $signed(i_data);
    assign o_flag = (w_x >= OUTLIER_POS_THRES) || (w_x <= OUTLIER_NEG_THRES);

endmodule

// File: rtl/llm_outlier_scan_ctrl.sv
// Scans one IN_DEPTH x IN_PARALLELISM activation tile, accumulating a per-lane outlier
// mask and total outlier count, then holds one summary until the scheduler accepts it.
module llm_outlier_scan_ctrl
    import llm_outlier_pkg::*;
#(
    parameter int IN_WIDTH       = 16,
    parameter int IN_PARALLELISM = 4,
    parameter int IN_DEPTH       = 8,
    parameter int CNT_WIDTH      = $clog2(IN_PARALLELISM * IN_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_PARALLELISM*IN_WIDTH-1:0] data_in_0,
    input  logic                               data_in_0_valid,
    output logic                               data_in_0_ready,
    output logic [IN_PARALLELISM-1:0]          mask_out,
    output logic [CNT_WIDTH-1:0]               count_out,
    output logic                               summary_valid,
    input  logic                               summary_ready
);

    localparam int                BEAT_W    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IN_DEPTH - 1);

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [IN_PARALLELISM-1:0] bits);
        logic [CNT_WIDTH-1:0] sum;
        sum = '0;
        for (int i = 0; i < IN_PARALLELISM; i++) begin
            sum = sum + CNT_WIDTH'(bits[i]);
        end
        return sum;
    endfunction

    scan_state_t                r_state;
    scan_state_t                w_state_nxt;
    logic [BEAT_W-1:0]          r_beat_cnt;
    logic [IN_PARALLELISM-1:0]  r_mask_acc;
    logic [CNT_WIDTH-1:0]       r_cnt_acc;

    logic [IN_PARALLELISM-1:0]  w_flags;
    logic [CNT_WIDTH-1:0]       w_pop;
    logic                       w_ready;
    logic                       w_hs;
    logic                       w_last;

    for (genvar g = 0; g < IN_PARALLELISM; g++) begin : g_lane
        llm_outlier_flag u_flag (
            .i_data (data_in_0[g*IN_WIDTH +: 16]),
            .o_flag (w_flags[g])
        );
    end

    assign w_pop   = popcount(w_flags);
    // Ready is forced low while rst is high so no beat is taken during the reset cycle.
    assign w_ready = (r_state == SCAN) && !rst;
    assign w_hs    = data_in_0_valid && w_ready;
    assign w_last  = (r_beat_cnt == LAST_BEAT);

    assign data_in_0_ready = w_ready;

    always_comb begin
        w_state_nxt   = r_state;
        summary_valid = 1'b0;
        case (r_state)
            SCAN: begin
                if (w_hs && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                summary_valid = 1'b1;
                if (summary_ready) begin
                    w_state_nxt = SCAN;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SCAN;
            r_beat_cnt <= '0;
            r_mask_acc <= '0;
            r_cnt_acc  <= '0;
            mask_out   <= '0;
            count_out  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                if (w_last) begin
                    // Final beat folds straight into the summary; accumulators restart for the next tile.
                    mask_out   <= r_mask_acc | w_flags;
                    count_out  <= r_cnt_acc + w_pop;
                    r_mask_acc <= '0;
                    r_cnt_acc  <= '0;
                    r_beat_cnt <= '0;
                end else begin
                    r_mask_acc <= r_mask_acc | w_flags;
                    r_cnt_acc  <= r_cnt_acc + w_pop;
                    r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_llm_outlier_scan_ctrl.sv
// Directed bench for llm_outlier_scan_ctrl (P=4, D=8) plus a single-beat-tile instance (D=1).
module tb_llm_outlier_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in_0;
    logic        data_in_0_valid;
    logic        data_in_0_ready;
    logic [3:0]  mask_out;
    logic [5:0]  count_out;
    logic        summary_valid;
    logic        summary_ready;

    logic [63:0] d1_data;
    logic        d1_valid;
    logic        d1_ready;
    logic [3:0]  d1_mask;
    logic [2:0]  d1_count;
    logic        d1_sv;
    logic        d1_sready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    llm_outlier_scan_ctrl #(.IN_WIDTH(16), .IN_PARALLELISM(4), .IN_DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in_0       (data_in_0),
        .data_in_0_valid (data_in_0_valid),
        .data_in_0_ready (data_in_0_ready),
        .mask_out        (mask_out),
        .count_out       (count_out),
        .summary_valid   (summary_valid),
        .summary_ready   (summary_ready)
    );

    llm_outlier_scan_ctrl #(.IN_WIDTH(16), .IN_PARALLELISM(4), .IN_DEPTH(1)) dut_d1 (
        .clk             (clk),
        .rst             (rst),
        .data_in_0       (d1_data),
        .data_in_0_valid (d1_valid),
        .data_in_0_ready (d1_ready),
        .mask_out        (d1_mask),
        .count_out       (d1_count),
        .summary_valid   (d1_sv),
        .summary_ready   (d1_sready)
    );

    function automatic logic [63:0] pack(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d);
        data_in_0       = d;
        data_in_0_valid = 1'b1;
        tick();
        data_in_0_valid = 1'b0;
        data_in_0       = 'x;
    endtask

    // Eight consecutive beats of the same data; summary must not appear before the last accept.
    task automatic send_tile(input string tag, input logic [63:0] d);
        for (int i = 0; i < 8; i++) begin
            send_beat(d);
            if (i == 6) chk({tag, "_sv_early"}, 32'(summary_valid), 32'd0);
        end
    endtask

    task automatic check_summary(input string tag, input logic [3:0] m, input logic [5:0] c);
        chk({tag, "_sv"},    32'(summary_valid),   32'd1);
        chk({tag, "_mask"},  32'(mask_out),        32'(m));
        chk({tag, "_count"}, 32'(count_out),       32'(c));
        chk({tag, "_rdy0"},  32'(data_in_0_ready), 32'd0);
        summary_ready = 1'b1;
        tick();
        summary_ready = 1'b0;
        chk({tag, "_sv_clr"}, 32'(summary_valid),   32'd0);
        chk({tag, "_rdy1"},   32'(data_in_0_ready), 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        data_in_0       = '0;
        data_in_0_valid = 1'b0;
        summary_ready   = 1'b0;
        d1_data         = '0;
        d1_valid        = 1'b0;
        d1_sready       = 1'b0;

        tick();
        tick();
        chk("rst_ready", 32'(data_in_0_ready), 32'd0);
        chk("rst_sv",    32'(summary_valid),   32'd0);
        chk("rst_mask",  32'(mask_out),        32'd0);
        chk("rst_count", 32'(count_out),       32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(data_in_0_ready), 32'd1);

        send_tile("zero", 64'd0);
        check_summary("zero", 4'b0000, 6'd0);

        send_tile("bound", pack(16'h007F, 16'h0080, 16'hFF81, 16'hFF80));
        check_summary("bound", 4'b1010, 6'd16);

        send_beat(pack(16'h0000, 16'h0000, 16'h0000, 16'hFF7F));
        for (int i = 0; i < 7; i++) send_beat(64'd0);
        check_summary("m129", 4'b1000, 6'd1);

        // Sparse valid: bubbles between beats, 0x7FFF on lane 2 of beat 5.
        for (int b = 0; b < 8; b++) begin
            send_beat((b == 5) ? pack(16'h0000, 16'h0000, 16'h7FFF, 16'h0000) : 64'd0);
            if (b == 7) break;
            tick();
            chk("sparse_sv_early", 32'(summary_valid), 32'd0);
        end
        check_summary("sparse", 4'b0100, 6'd1);

        // Backpressure with outlier data offered while the summary waits.
        send_tile("bp", pack(16'h0100, 16'h0000, 16'h0000, 16'h0000));
        data_in_0       = {4{16'h8000}};
        data_in_0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_rdy",   32'(data_in_0_ready), 32'd0);
            chk("bp_sv",    32'(summary_valid),   32'd1);
            chk("bp_mask",  32'(mask_out),        32'b0001);
            chk("bp_count", 32'(count_out),       32'd8);
        end
        data_in_0_valid = 1'b0;
        check_summary("bp", 4'b0001, 6'd8);
        send_tile("after_bp", 64'd0);
        check_summary("after_bp", 4'b0000, 6'd0);

        // Reset mid-tile drops the partial accumulation.
        for (int i = 0; i < 3; i++) send_beat({4{16'h8000}});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_sv",  32'(summary_valid),   32'd0);
        chk("midrst_rdy", 32'(data_in_0_ready), 32'd1);
        send_tile("midrst", 64'd0);
        check_summary("midrst", 4'b0000, 6'd0);

        send_tile("all1", {4{16'h8000}});
        check_summary("all1", 4'b1111, 6'd32);
        send_tile("all2", {4{16'h8000}});
        check_summary("all2", 4'b1111, 6'd32);

        // Depth-1 instance: each accepted beat completes a tile.
        chk("d1_rdy", 32'(d1_ready), 32'd1);
        d1_data  = pack(16'h00C8, 16'h0005, 16'hFF80, 16'h0000);
        d1_valid = 1'b1;
        tick();
        d1_valid = 1'b0;
        chk("d1_sv",    32'(d1_sv),    32'd1);
        chk("d1_mask",  32'(d1_mask),  32'b0101);
        chk("d1_count", 32'(d1_count), 32'd2);
        chk("d1_rdy0",  32'(d1_ready), 32'd0);
        d1_sready = 1'b1;
        tick();
        d1_sready = 1'b0;
        chk("d1_sv_clr", 32'(d1_sv), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
